// File: rtl/muldiv_ctrl.sv
// Multiply/divide unit sequencer for the EX stage: single-cycle mult/multu,
// 32-cycle restoring div/divu, and a one-cycle HILO write strobe on completion.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        startE,
    input  logic [1:0]  opE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        cancel,
    output logic        stall_req,
    output logic        hilo_wen,
    output logic [63:0] hilo_o,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  op_reg;
    logic [31:0] a_reg, b_reg;
    logic [31:0] rem_reg, quo_reg;
    logic [4:0]  cnt_reg;
    logic [63:0] hilo_reg;

    logic        a_neg, b_neg;
    logic [31:0] b_mag, srca_mag_in;
    logic [32:0] shifted, diff;
    logic        fits;
    logic [31:0] rem_step, quo_step, q_final, r_final;
    logic [63:0] mul_a, mul_b, product;

    // Extending each operand to 64 bits per op lets one unsigned multiplier
    // serve both mult and multu.
    assign mul_a   = {{32{~op_reg[0] & a_reg[31]}}, a_reg};
    assign mul_b   = {{32{~op_reg[0] & b_reg[31]}}, b_reg};
    assign product = mul_a * mul_b;

    assign a_neg       = (op_reg == 2'b10) & a_reg[31];
    assign b_neg       = (op_reg == 2'b10) & b_reg[31];
    assign b_mag       = b_neg ? -b_reg : b_reg;
    assign srca_mag_in = ((opE == 2'b10) && srcaE[31]) ? -srcaE : srcaE;

    // One restoring step: shift next dividend bit into the partial remainder.
    assign shifted  = {rem_reg, quo_reg[31]};
    assign diff     = shifted - {1'b0, b_mag};
    assign fits     = ~diff[32];
    assign rem_step = fits ? diff[31:0] : shifted[31:0];
    assign quo_step = {quo_reg[30:0], fits};
    assign q_final  = (a_neg ^ b_neg) ? -quo_step : quo_step;
    assign r_final  = a_neg ? -rem_step : rem_step;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (startE) begin
                    if (!opE[1])
                        state_next = MUL;
                    else if (srcbE == 32'd0)
                        state_next = DONE;
                    else
                        state_next = DIV;
                end
            end
            MUL:     state_next = DONE;
            DIV:     if (cnt_reg == 5'd31) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (cancel)
            state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            op_reg    <= 2'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            rem_reg   <= 32'd0;
            quo_reg   <= 32'd0;
            cnt_reg   <= 5'd0;
            hilo_reg  <= 64'd0;
        end else begin
            state_reg <= state_next;
            if (!cancel) begin
                case (state_reg)
                    IDLE: begin
                        if (startE) begin
                            op_reg  <= opE;
                            a_reg   <= srcaE;
                            b_reg   <= srcbE;
                            cnt_reg <= 5'd0;
                            rem_reg <= 32'd0;
                            quo_reg <= srca_mag_in;
                            if (opE[1] && (srcbE == 32'd0))
                                hilo_reg <= {srcaE, 32'hFFFF_FFFF};
                        end
                    end
                    MUL: hilo_reg <= product;
                    DIV: begin
                        cnt_reg <= cnt_reg + 5'd1;
                        rem_reg <= rem_step;
                        quo_reg <= quo_step;
                        if (cnt_reg == 5'd31)
                            hilo_reg <= {r_final, q_final};
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy      = (state_reg != IDLE);
    assign hilo_wen  = (state_reg == DONE) & ~cancel & ~rst;
    assign stall_req = ~cancel & (((state_reg == IDLE) & startE) |
                                  (state_reg == MUL) | (state_reg == DIV));
    assign hilo_o    = hilo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: a transaction-level model predicts stall,
// busy, HILO strobe and value every cycle; literal results pin the model.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        startE = 1'b0;
    logic [1:0]  opE = 2'b00;
    logic [31:0] srcaE = 32'd0;
    logic [31:0] srcbE = 32'd0;
    logic        cancel = 1'b0;
    logic        stall_req, hilo_wen, busy;
    logic [63:0] hilo_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          wen_cyc = -1;
    logic [63:0] wen_val = 64'd0;

    bit          m_active = 1'b0;
    int          m_start = 0;
    int          m_lat = 0;
    logic [63:0] m_res = 64'd0;
    logic [63:0] m_hilo = 64'd0;

    muldiv_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .startE    (startE),
        .opE       (opE),
        .srcaE     (srcaE),
        .srcbE     (srcbE),
        .cancel    (cancel),
        .stall_req (stall_req),
        .hilo_wen  (hilo_wen),
        .hilo_o    (hilo_o),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: res = 64'(sa * sb);
            2'b01: res = {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0)
                    res = {a, 32'hFFFF_FFFF};
                else if (op == 2'b11)
                    res = {a % b, a / b};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    res = {32'd0, 32'h8000_0000};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] b);
        if (!op[1]) return 2;
        if (b == 32'd0) return 1;
        return 33;
    endfunction

    // Per-cycle compare against the model, then advance the model one cycle.
    always @(negedge clk) begin
        bit in_fsm, in_done, exp_stall, exp_wen;
        if (cyc >= 1) begin
            in_fsm    = m_active && (cyc > m_start);
            in_done   = m_active && (cyc == m_start + m_lat);
            exp_stall = !cancel && ((!in_fsm && startE) || (in_fsm && !in_done));
            exp_wen   = in_done && !cancel && !rst;
            chk("stall_req", 64'(stall_req), 64'(exp_stall));
            chk("hilo_wen", 64'(hilo_wen), 64'(exp_wen));
            if (!rst) chk("busy", 64'(busy), 64'(in_fsm));
            chk("hilo_o", hilo_o, in_done ? m_res : m_hilo);
            if (hilo_wen) begin
                wen_cyc = cyc;
                wen_val = hilo_o;
            end
            if (rst) begin
                m_active = 1'b0;
                m_hilo   = 64'd0;
            end else begin
                if (in_done) m_hilo = m_res;
                if (cancel || in_done)
                    m_active = 1'b0;
                else if (!in_fsm && startE) begin
                    m_active = 1'b1;
                    m_start  = cyc;
                    m_lat    = model_lat(opE, srcbE);
                    m_res    = model_res(opE, srcaE, srcbE);
                end
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int t);
        wen_cyc = -1;
        startE = 1'b1;
        opE = op;
        srcaE = a;
        srcbE = b;
        t = cyc;
        @(posedge clk);
        #1;
        startE = 1'b0;
    endtask

    task automatic expect_result(input string name, input int t, input int lat,
                                 input logic [63:0] exp);
        goto(t + lat + 1);
        chk({name, "_cycle"}, 64'(wen_cyc), 64'(t + lat));
        chk({name, "_value"}, wen_val, exp);
        $display("txn %s issued=%0d wen=%0d hilo=%h", name, t, wen_cyc, wen_val);
    endtask

    initial begin
        int t;
        goto(3);
        chk("reset_hilo", hilo_o, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        goto(5);

        issue(2'b00, 32'hFFFF_FFFD, 32'd5, t);
        expect_result("mult_m3x5", t, 2, 64'hFFFF_FFFF_FFFF_FFF1);
        issue(2'b01, 32'hFFFF_FFFF, 32'd2, t);
        expect_result("multu", t, 2, 64'h0000_0001_FFFF_FFFE);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, t);
        expect_result("div_m7_2", t, 33, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(2'b11, 32'h1234_5678, 32'd0, t);
        expect_result("divu_by0", t, 1, 64'h1234_5678_FFFF_FFFF);
        issue(2'b10, 32'hFFFF_FFFB, 32'd0, t);
        expect_result("div_by0", t, 1, 64'hFFFF_FFFB_FFFF_FFFF);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, t);
        expect_result("div_ovf", t, 33, 64'h0000_0000_8000_0000);
        issue(2'b10, 32'd7, 32'hFFFF_FFFE, t);
        expect_result("div_7_m2", t, 33, 64'h0000_0001_FFFF_FFFD);

        // Cancel mid-divide, then a fresh divide two cycles later.
        issue(2'b10, 32'd100, 32'd7, t);
        goto(t + 10);
        cancel = 1'b1;
        #1;
        chk("cancel_stall", 64'(stall_req), 64'd0);
        goto(t + 11);
        cancel = 1'b0;
        chk("cancel_idle", 64'(busy), 64'd0);
        goto(t + 12);
        chk("cancel_no_wen", 64'(wen_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        issue(2'b10, 32'd100, 32'd7, t);
        expect_result("div_100_7", t, 33, 64'h0000_0002_0000_000E);

        // startE held through MUL and DONE must not launch a second op.
        wen_cyc = -1;
        startE = 1'b1; opE = 2'b01; srcaE = 32'd6; srcbE = 32'd7;
        t = cyc;
        goto(t + 3);
        startE = 1'b0;
        chk("held_start_cycle", 64'(wen_cyc), 64'(t + 2));
        chk("held_start_value", wen_val, 64'd42);
        goto(t + 6);

        // Cancel in DONE suppresses the strobe.
        issue(2'b00, 32'd3, 32'd4, t);
        goto(t + 2);
        cancel = 1'b1;
        goto(t + 3);
        cancel = 1'b0;
        chk("cancel_done_no_wen", 64'(wen_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        $display("txn cancel_done issued=%0d wen=%0d", t, wen_cyc);

        // Reset mid-divu aborts without a write.
        issue(2'b11, 32'd1000, 32'd3, t);
        goto(t + 5);
        rst = 1'b1;
        goto(t + 6);
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hilo", hilo_o, 64'd0);
        goto(t + 40);
        chk("rst_no_wen", 64'(wen_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        $display("txn rst_divu issued=%0d wen=%0d", t, wen_cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have clock and reset: one clock; reset is synchronous and active-high.
REQ-002 Port list:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- startE  in  1  a mult/multu/div/divu is in EX
- opE  in  2  00 mult, 01 multu, 10 div, 11 divu
- srcaE  in  32  rs operand
- srcbE  in  32  rt operand
- cancel  in  1  exception/flush abort; drops any operation in flight
- stall_req  out  1  holds the pipeline front while the unit is busy
- hilo_wen  out  1  one-cycle HILO write strobe
- hilo_o  out  64  {HI, LO} result
- busy  out  1  state != IDLE

Function
REQ-003 SHALL use FSM states IDLE, MUL, DIV, DONE.
REQ-004 IDLE & startE & ~cancel SHALL capture opE, srcaE and srcbE, then go to:
- MUL for op 0x;
- DONE for op 1x with srcbE==0;
- DIV otherwise.
REQ-005 MUL SHALL compute the 64-bit product in one cycle, signed for op 00 and unsigned for op 01, register it, then go to DONE.
REQ-006 DIV SHALL run a 32-iteration restoring division on operand magnitudes:
- 5-bit counter, 0 at entry;
- one quotient bit per cycle;
- exit to DONE on the cycle counter==31.
REQ-007 Signed divide (op 10) SHALL apply quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a).
REQ-008 Signed divide SHALL make 0x80000000 / -1 return LO=0x80000000, HI=0.
REQ-009 Divide result SHALL be HI=remainder, LO=quotient.
REQ-010 Divide by zero SHALL give HI=captured srca and LO=0xFFFFFFFF, for both div and divu.
REQ-011 DONE SHALL assert hilo_wen=1 for exactly one cycle, hold hilo_o valid, and return to IDLE next cycle.
REQ-012 stall_req SHALL be combinational: (state==IDLE & startE) | state==MUL | state==DIV, forced 0 when cancel=1.
REQ-013 stall_req SHALL be 0 in DONE so the stalled instruction advances as HILO is written.
REQ-014 Latency, start sampled at cycle T:
- mult: stall T..T+1, hilo_wen at T+2;
- div: stall T..T+32, hilo_wen at T+33;
- divide by zero: stall T, hilo_wen at T+1.
REQ-015 cancel=1 in any state SHALL send the FSM to IDLE next cycle.
REQ-016 cancel in DONE SHALL suppress hilo_wen that cycle.
REQ-017 startE SHALL be ignored outside IDLE; in DONE it belongs to the retiring instruction.
REQ-018 hilo_o SHALL hold its last value while not in DONE; only hilo_wen qualifies it.

Reset
REQ-019 rst=1 SHALL force, on the next edge, state=IDLE, counter=0, internal remainder/quotient/operand registers=0, hilo_o=0.
REQ-020 During and after reset, hilo_wen=0, busy=0, and stall_req follows REQ-012.
REQ-021 rst SHALL take priority over cancel and startE.
REQ-022 rst asserted mid-DIV SHALL abort the operation with no HILO write.

Verification
REQ-023 mult, srca=0xFFFFFFFD (-3), srcb=5 -> stall_req at T,T+1; hilo_wen at T+2; hilo_o=0xFFFFFFFF_FFFFFFF1.
REQ-024 multu, srca=0xFFFFFFFF, srcb=2 -> hilo_o=0x00000001_FFFFFFFE at T+2.
REQ-025 div, srca=0xFFFFFFF9 (-7), srcb=2 -> stall_req T..T+32; hilo_wen only at T+33; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-026 divu, srca=0x12345678, srcb=0 -> hilo_wen at T+1; HI=0x12345678, LO=0xFFFFFFFF.
REQ-027 div 100/7 with cancel=1 at T+10 -> stall_req=0 at T+10; IDLE at T+11; no hilo_wen.
REQ-028 New div issued at T+12 -> completes normally with LO=14, HI=2.
REQ-029 rst=1 at T+5 of a divu -> busy=0, hilo_o=0 next cycle; hilo_wen never asserted.
